usb_uart_tx_arbiter: RTL and testbench
======================================

// Module: usb_uart_tx_arbiter
// PURPOSE
//  Shares the single USB-UART transmitter among NREQ byte sources using round-robin arbitration.
//  Issues the UART reset pulse after BTND. Drives the UART transmitter interface (tdin, wrn, tbre).
//  Adds a tbre watchdog that recovers from a stalled transmitter.
//  Sits between the application byte producers (status, echo, logger...) and the UART core.
// PARAMETERS
//  NREQ     4     number of requesters, 2..8; index width IW = clog2(NREQ)
//  WRN_CYC  1     wrn high time in genclk cycles, >=1
//  TMO_CYC  4096  watchdog limit in genclk cycles for a tbre wait, >=2
// PORTS
//  genclk  in   1        system clock; all logic on the rising edge
//  BTND    in   1        reset; synchronous, active-high
//  req     in   NREQ     per-requester "byte pending"; held until ack
//  din     in   8*NREQ   flattened data; byte i = din[8*i+7:8*i], stable while req[i]=1
//  ack     out  NREQ     one-cycle pulse: byte i has been written to the UART
//  owner   out  IW       index of the current/last granted requester
//  busy    out  1        1 whenever the state is not IDLE
//  tmo     out  1        sticky watchdog flag; cleared only by BTND
//  rdrst   out  1        UART reset pulse
//  tdin    out  8        UART transmit data
//  tbre    in   1        UART transmit buffer status; 0 = empty/ready, 1 = busy
//  wrn     out  1        UART write strobe, active-high
// BEHAVIOUR
//  Reset (BTND=1 at a clock edge) wins over all other events, including mid-transfer:
//   state=RST, rdrst=0, wrn=0, tdin=0, ack=0, owner=0, ptr=0, tmo=0, cnt=0.
//  The byte in flight is abandoned without ack.
//  States:
//   RST:    rdrst<=1 -> REL
//   REL:    rdrst<=0 -> IDLE
//   IDLE:   if |req, winner w = first i with req[i]=1 searching ptr, ptr+1, ...
//           mod NREQ; tdin<=din[w], owner<=w, cnt<=0 -> WAITE. Else stay.
//   WAITE:  if tbre==0: wrn<=1, cnt<=0 -> STROBE.
//           Else cnt++; at cnt==TMO_CYC-1: tmo<=1, ptr<=w+1, no ack -> RST (byte dropped).
//   STROBE: wrn stays 1 for exactly WRN_CYC cycles total. On the last one: wrn<=0,
//           ack[w]<=1, ptr<=(w+1) mod NREQ, cnt<=0 -> DRAIN.
//   DRAIN:  ack<=0 (ack is high only in the first DRAIN cycle). If tbre==1
//           (transmitter took the byte) -> IDLE. Else cnt++; at cnt==TMO_CYC-1:
//           tmo<=1 -> RST. The ack has already been issued and is not repeated.
//  - tdin is registered and stays constant from the IDLE exit until the next grant.
//  - Latency: req seen in IDLE with tbre=0 gives wrn high 2 cycles later. ack arrives
//    WRN_CYC+2 cycles after the grant edge.
//  - Min issue period per byte: 1(IDLE)+1(WAITE)+WRN_CYC+DRAIN time.
//  - req changes outside IDLE are ignored. A requester whose req drops before its grant
//    simply loses its turn; no ack is produced.
//  - Simultaneous requests: round robin only, no fixed priority. After a grant to w,
//    w has the lowest priority.
//  - Pointer wrap: ptr=NREQ-1 grant -> ptr=0.
//  - cnt width = clog2(TMO_CYC). It saturates and never wraps.
//  - Illegal state -> RST.
// TESTING
//  1 Reset: BTND high 3 cycles, then low. Required: rdrst=1 for exactly cycle 1 after
//    release; IDLE by cycle 2; all other outputs 0.
//  2 Single byte: req=0001, din0=8'hA5, tbre=0. Required: wrn=1 for WRN_CYC cycles with
//    tdin=A5; then tbre=1 -> ack=0001 for 1 cycle -> IDLE.
//  3 Fairness: req=1111 held, bytes 10/11/12/13, tbre toggles per write. Required:
//    grant order 0,1,2,3,0 and owner tracks it.
//  4 Stall in WAITE: tbre held 1 for TMO_CYC cycles. Required: tmo=1, no ack, rdrst
//    pulse, next grant goes to w+1.
//  5 Stall in DRAIN: tbre stays 0 after wrn. Required: ack once, then tmo=1 after
//    TMO_CYC cycles, rdrst pulse.
//  6 BTND during STROBE with req=0100. Required: wrn=0 next cycle, no ack, tmo cleared,
//    restart from RST.

Source files
------------

// File: rtl/usb_uart_tx_arbiter_if.sv
// Byte-source and UART-transmitter signal bundle for the shared USB-UART TX arbiter.
// master = arbiter side, slave = producers/UART side.
interface usb_uart_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] din;
    logic [NREQ-1:0]   ack;
    logic [IW-1:0]     owner;
    logic              busy;
    logic              tmo;
    logic              rdrst;
    logic [7:0]        tdin;
    logic              tbre;
    logic              wrn;

    modport master (
        input  req, din, tbre,
        output ack, owner, busy, tmo, rdrst, tdin, wrn
    );

    modport slave (
        output req, din, tbre,
        input  ack, owner, busy, tmo, rdrst, tdin, wrn
    );
endinterface

// File: rtl/usb_uart_tx_arbiter.sv
// Round-robin sharing of one USB-UART transmitter among NREQ byte sources,
// with UART reset sequencing and a tbre watchdog that recovers a stalled transmitter.
module usb_uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int WRN_CYC = 1,
    parameter int TMO_CYC = 4096
) (
    input  logic                  genclk,
    input  logic                  BTND,
    usb_uart_tx_arbiter_if.master bus
);
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX = (TMO_CYC > WRN_CYC) ? TMO_CYC : WRN_CYC;
    localparam int CW   = $clog2(CMAX);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);
    localparam logic [CW-1:0] WRN_LAST = CW'(WRN_CYC - 1);

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_REL    = 3'd1,
        ST_IDLE   = 3'd2,
        ST_WAITE  = 3'd3,
        ST_STROBE = 3'd4,
        ST_DRAIN  = 3'd5
    } state_t;

    state_t          state_r, state_s;
    logic [IW-1:0]   ptr_r, ptr_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [IW-1:0]   owner_r, owner_s;
    logic [NREQ-1:0] ack_r, ack_s;
    logic [7:0]      tdin_r, tdin_s;
    logic            wrn_r, wrn_s;
    logic            tmo_r, tmo_s;
    logic            rdrst_r, rdrst_s;
    logic            busy_r;
    logic [IW-1:0]   win_s;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] w);
        if (w == IW'(NREQ - 1)) begin
            return '0;
        end else begin
            return w + IW'(1);
        end
    endfunction

    // Saturating increment: the counter never wraps back to zero.
    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
        if (c == {CW{1'b1}}) begin
            return c;
        end else begin
            return c + CW'(1);
        end
    endfunction

    // Round-robin winner: descending scan so the requester closest after ptr wins.
    always_comb begin
        int idx;
        win_s = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx   = (int'(ptr_r) + i) % NREQ;
            win_s = bus.req[idx] ? IW'(idx) : win_s;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        cnt_s   = cnt_r;
        owner_s = owner_r;
        ack_s   = '0;
        tdin_s  = tdin_r;
        wrn_s   = wrn_r;
        tmo_s   = tmo_r;
        rdrst_s = rdrst_r;
        case (state_r)
            ST_RST: begin
                rdrst_s = 1'b1;
                state_s = ST_REL;
            end
            ST_REL: begin
                rdrst_s = 1'b0;
                state_s = ST_IDLE;
            end
            ST_IDLE: begin
                if (|bus.req) begin
                    tdin_s  = bus.din[{win_s, 3'b000} +: 8];
                    owner_s = win_s;
                    cnt_s   = '0;
                    state_s = ST_WAITE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAITE: begin
                if (!bus.tbre) begin
                    wrn_s   = 1'b1;
                    cnt_s   = '0;
                    state_s = ST_STROBE;
                end else if (cnt_r == TMO_LAST) begin
                    // Transmitter never became ready: drop the byte, skip this owner.
                    tmo_s   = 1'b1;
                    ptr_s   = next_idx(owner_r);
                    cnt_s   = '0;
                    state_s = ST_RST;
                end else begin
                    cnt_s = cnt_inc(cnt_r);
                end
            end
            ST_STROBE: begin
                if (cnt_r >= WRN_LAST) begin
                    wrn_s   = 1'b0;
                    ack_s   = NREQ'(1) << owner_r;
                    ptr_s   = next_idx(owner_r);
                    cnt_s   = '0;
                    state_s = ST_DRAIN;
                end else begin
                    cnt_s = cnt_inc(cnt_r);
                end
            end
            ST_DRAIN: begin
                if (bus.tbre) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == TMO_LAST) begin
                    tmo_s   = 1'b1;
                    cnt_s   = '0;
                    state_s = ST_RST;
                end else begin
                    cnt_s = cnt_inc(cnt_r);
                end
            end
            default: begin
                wrn_s   = 1'b0;
                rdrst_s = 1'b0;
                state_s = ST_RST;
            end
        endcase
    end

    // State and output registers; BTND abandons any byte in flight.
    always_ff @(posedge genclk) begin
        if (BTND) begin
            state_r <= ST_RST;
            ptr_r   <= '0;
            cnt_r   <= '0;
            owner_r <= '0;
            ack_r   <= '0;
            tdin_r  <= 8'h00;
            wrn_r   <= 1'b0;
            tmo_r   <= 1'b0;
            rdrst_r <= 1'b0;
            busy_r  <= 1'b1;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
            owner_r <= owner_s;
            ack_r   <= ack_s;
            tdin_r  <= tdin_s;
            wrn_r   <= wrn_s;
            tmo_r   <= tmo_s;
            rdrst_r <= rdrst_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    assign bus.ack   = ack_r;
    assign bus.owner = owner_r;
    assign bus.busy  = busy_r;
    assign bus.tmo   = tmo_r;
    assign bus.rdrst = rdrst_r;
    assign bus.tdin  = tdin_r;
    assign bus.wrn   = wrn_r;
endmodule

// File: tb/tb_usb_uart_tx_arbiter.sv
// Directed bench for usb_uart_tx_arbiter: NREQ=4, WRN_CYC=2, TMO_CYC=16.
module tb_usb_uart_tx_arbiter;
    localparam int NREQ = 4;

    logic genclk = 1'b0;
    logic BTND;
    int   passes = 0;
    int   total  = 0;

    usb_uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    usb_uart_tx_arbiter #(.NREQ(NREQ), .WRN_CYC(2), .TMO_CYC(16)) dut (
        .genclk (genclk),
        .BTND   (BTND),
        .bus    (bus.master)
    );

    always #5 genclk = ~genclk;

    task automatic tick();
        @(posedge genclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One full transfer from IDLE with tbre toggling; WRN_CYC=2.
    task automatic xfer(input int w, input logic [7:0] b);
        tick();
        chk($sformatf("grant_owner%0d", w), 32'(bus.owner), 32'(w));
        chk($sformatf("grant_tdin%0d", w), 32'(bus.tdin), 32'(b));
        tick();
        chk($sformatf("wrn_hi%0d", w), 32'(bus.wrn), 32'd1);
        tick();
        tick();
        chk($sformatf("ack%0d", w), 32'(bus.ack), 32'(4'b0001 << w));
        bus.tbre = 1'b1;
        tick();
        chk($sformatf("idle%0d", w), 32'(bus.busy), 32'd0);
        bus.tbre = 1'b0;
    endtask

    initial begin
        int ack_seen;
        BTND     = 1'b1;
        bus.req  = 4'b0000;
        bus.din  = 32'h0;
        bus.tbre = 1'b0;

        // 1: reset held three cycles
        tick(); tick(); tick();
        chk("rst_rdrst", 32'(bus.rdrst), 32'd0);
        chk("rst_wrn", 32'(bus.wrn), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd0);
        chk("rst_tmo", 32'(bus.tmo), 32'd0);
        chk("rst_tdin", 32'(bus.tdin), 32'd0);
        BTND = 1'b0;
        tick();
        chk("rel_rdrst1", 32'(bus.rdrst), 32'd1);
        tick();
        chk("rel_rdrst0", 32'(bus.rdrst), 32'd0);
        chk("rel_idle", 32'(bus.busy), 32'd0);

        // 2: single byte
        bus.req = 4'b0001;
        bus.din = 32'h0000_00A5;
        tick();
        chk("sb_tdin", 32'(bus.tdin), 32'hA5);
        chk("sb_busy", 32'(bus.busy), 32'd1);
        chk("sb_wrn_pre", 32'(bus.wrn), 32'd0);
        tick();
        chk("sb_wrn1", 32'(bus.wrn), 32'd1);
        tick();
        chk("sb_wrn2", 32'(bus.wrn), 32'd1);
        chk("sb_tdin_hold", 32'(bus.tdin), 32'hA5);
        tick();
        chk("sb_wrn_lo", 32'(bus.wrn), 32'd0);
        chk("sb_ack", 32'(bus.ack), 32'h1);
        bus.req  = 4'b0000;
        bus.tbre = 1'b1;
        tick();
        chk("sb_ack_lo", 32'(bus.ack), 32'h0);
        chk("sb_idle", 32'(bus.busy), 32'd0);
        bus.tbre = 1'b0;

        // 3: fairness from a fresh pointer, including the 3 -> 0 wrap
        BTND = 1'b1;
        tick();
        BTND = 1'b0;
        tick(); tick();
        bus.req = 4'b1111;
        bus.din = 32'h1312_1110;
        xfer(0, 8'h10);
        xfer(1, 8'h11);
        xfer(2, 8'h12);
        xfer(3, 8'h13);
        xfer(0, 8'h10);
        bus.req = 4'b0000;

        // 4: tbre stuck high in WAITE; pointer is now 1
        bus.req  = 4'b0010;
        bus.tbre = 1'b1;
        tick();
        chk("w_owner", 32'(bus.owner), 32'd1);
        bus.req = 4'b0000;
        ack_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            ack_seen += int'(|bus.ack);
        end
        chk("w_tmo_pre", 32'(bus.tmo), 32'd0);
        tick();
        chk("w_tmo", 32'(bus.tmo), 32'd1);
        chk("w_noack", 32'(ack_seen + int'(|bus.ack)), 32'd0);
        bus.tbre = 1'b0;
        bus.req  = 4'b0110;
        tick();
        chk("w_rdrst1", 32'(bus.rdrst), 32'd1);
        tick();
        chk("w_rdrst0", 32'(bus.rdrst), 32'd0);
        tick();
        chk("w_next_owner", 32'(bus.owner), 32'd2);
        chk("w_next_tdin", 32'(bus.tdin), 32'h12);
        chk("w_tmo_sticky", 32'(bus.tmo), 32'd1);

        // 6: BTND during STROBE
        bus.req = 4'b0100;
        tick();
        chk("b_wrn_hi", 32'(bus.wrn), 32'd1);
        BTND = 1'b1;
        tick();
        chk("b_wrn_lo", 32'(bus.wrn), 32'd0);
        chk("b_ack", 32'(bus.ack), 32'd0);
        chk("b_tmo", 32'(bus.tmo), 32'd0);
        chk("b_owner", 32'(bus.owner), 32'd0);
        BTND    = 1'b0;
        bus.req = 4'b0000;
        tick();
        chk("b_rdrst1", 32'(bus.rdrst), 32'd1);
        chk("b_ack2", 32'(bus.ack), 32'd0);
        tick();
        chk("b_idle", 32'(bus.busy), 32'd0);

        // 5: tbre never rises after the write, DRAIN watchdog
        bus.req = 4'b0001;
        tick();
        chk("d_owner", 32'(bus.owner), 32'd0);
        tick(); tick(); tick();
        chk("d_ack", 32'(bus.ack), 32'h1);
        bus.req = 4'b0000;
        ack_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            ack_seen += int'(|bus.ack);
        end
        chk("d_ack_once", 32'(ack_seen), 32'd0);
        chk("d_tmo_pre", 32'(bus.tmo), 32'd0);
        tick();
        chk("d_tmo", 32'(bus.tmo), 32'd1);
        tick();
        chk("d_rdrst1", 32'(bus.rdrst), 32'd1);
        tick();
        chk("d_rdrst0", 32'(bus.rdrst), 32'd0);
        chk("d_idle", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
